// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I-subset sequencer: FSM states,
// instruction classes, ALU codes and opcode/funct field constants.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_TRAP      = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_ADDI    = 3'd0,
    CLS_ADD     = 3'd1,
    CLS_SUB     = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_BNE     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  function automatic logic is_branch(input instr_class_e c);
    return (c == CLS_BEQ) || (c == CLS_BNE);
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational decoder: classifies an instruction word and extracts register
// fields plus the sign-extended I-type and B-type immediates.
module rv_decoder
  import rv_ctrl_pkg::*;
#(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 5,
  parameter int PC_WIDTH = 16
) (
  input  logic [31:0]         instr,
  output instr_class_e        cls,
  output logic [A_WIDTH-1:0]  rs1,
  output logic [A_WIDTH-1:0]  rs2,
  output logic [A_WIDTH-1:0]  rd,
  output logic [D_WIDTH-1:0]  imm_i,
  output logic [PC_WIDTH-1:0] imm_b
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign rs1 = A_WIDTH'(instr[19:15]);
  assign rs2 = A_WIDTH'(instr[24:20]);
  assign rd  = A_WIDTH'(instr[11:7]);

  // Immediates are sign-extended to 32 bits first, then cut to the target width.
  assign imm_i = D_WIDTH'({{20{instr[31]}}, instr[31:20]});
  assign imm_b = PC_WIDTH'({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});

  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_IMM: begin
        if (funct3 == F3_ADD) cls = CLS_ADDI;
      end
      OP_REG: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) cls = CLS_ADD;
        else if (funct3 == F3_ADD && funct7 == F7_SUB) cls = CLS_SUB;
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) cls = CLS_BEQ;
        else if (funct3 == F3_BNE) cls = CLS_BNE;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer driving the register
// file and ALU for ADDI/ADD/SUB/BEQ/BNE; owns the PC and traps on anything else.
module rf_alu_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 5,
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                eq,
  output logic [A_WIDTH-1:0]  ad1,
  output logic [A_WIDTH-1:0]  ad2,
  output logic [A_WIDTH-1:0]  ad3,
  output logic                we3,
  output logic [D_WIDTH-1:0]  imm_op,
  output logic                alusrc,
  output logic [2:0]          aluctrl,
  output logic                illegal
);

  state_e                state_reg;
  logic [31:0]           instr_reg;
  logic [PC_WIDTH-1:0]   pc_reg;
  logic                  ready_reg;
  logic [A_WIDTH-1:0]    ad1_reg, ad2_reg, ad3_reg;
  logic                  we3_reg;
  logic [D_WIDTH-1:0]    imm_reg;
  logic                  alusrc_reg;
  logic [2:0]            aluctrl_reg;
  logic                  illegal_reg;

  logic [31:0]           dec_instr;
  instr_class_e          dec_cls;
  logic [A_WIDTH-1:0]    dec_rs1, dec_rs2, dec_rd;
  logic [D_WIDTH-1:0]    dec_imm_i;
  logic [PC_WIDTH-1:0]   dec_imm_b;
  logic                  branch_taken;

  // In FETCH the live word is decoded so controls are registered at the
  // handshake and already valid during DECODE; afterwards the held copy is used.
  assign dec_instr = (state_reg == ST_FETCH) ? instr : instr_reg;

  rv_decoder #(
    .D_WIDTH (D_WIDTH),
    .A_WIDTH (A_WIDTH),
    .PC_WIDTH(PC_WIDTH)
  ) u_decoder (
    .instr(dec_instr),
    .cls  (dec_cls),
    .rs1  (dec_rs1),
    .rs2  (dec_rs2),
    .rd   (dec_rd),
    .imm_i(dec_imm_i),
    .imm_b(dec_imm_b)
  );

  assign branch_taken = (dec_cls == CLS_BEQ && eq) || (dec_cls == CLS_BNE && !eq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_FETCH;
      instr_reg   <= '0;
      pc_reg      <= PC_RESET;
      ready_reg   <= 1'b1;
      ad1_reg     <= '0;
      ad2_reg     <= '0;
      ad3_reg     <= '0;
      we3_reg     <= 1'b0;
      imm_reg     <= '0;
      alusrc_reg  <= 1'b0;
      aluctrl_reg <= ALU_ADD;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (instr_valid && ready_reg) begin
            instr_reg   <= instr;
            ready_reg   <= 1'b0;
            ad1_reg     <= dec_rs1;
            ad2_reg     <= dec_rs2;
            ad3_reg     <= dec_rd;
            imm_reg     <= dec_imm_i;
            alusrc_reg  <= (dec_cls == CLS_ADDI);
            aluctrl_reg <= (dec_cls == CLS_ADDI || dec_cls == CLS_ADD) ? ALU_ADD : ALU_SUB;
            state_reg   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_cls == CLS_ILLEGAL) begin
            illegal_reg <= 1'b1;
            state_reg   <= ST_TRAP;
          end else begin
            state_reg   <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_branch(dec_cls)) begin
            pc_reg    <= branch_taken ? pc_reg + dec_imm_b : pc_reg + PC_WIDTH'(4);
            ready_reg <= 1'b1;
            state_reg <= ST_FETCH;
          end else begin
            we3_reg   <= (ad3_reg != '0);
            state_reg <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          we3_reg   <= 1'b0;
          pc_reg    <= pc_reg + PC_WIDTH'(4);
          ready_reg <= 1'b1;
          state_reg <= ST_FETCH;
        end
        ST_TRAP: begin
          we3_reg <= 1'b0;
        end
        default: begin
          we3_reg   <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= ST_FETCH;
        end
      endcase
    end
  end

  assign instr_ready = ready_reg;
  assign pc          = pc_reg;
  assign ad1         = ad1_reg;
  assign ad2         = ad2_reg;
  assign ad3         = ad3_reg;
  assign we3         = we3_reg;
  assign imm_op      = imm_reg;
  assign alusrc      = alusrc_reg;
  assign aluctrl     = aluctrl_reg;
  assign illegal     = illegal_reg;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Randomized bench for rf_alu_sequencer: two instances (16-bit and 4-bit PC)
// share one instruction stream and are checked against a transaction-level model.
module tb_rf_alu_sequencer;

  localparam int K_ADDI = 0, K_ADD = 1, K_SUB = 2, K_BEQ = 3, K_BNE = 4, K_ILL = 5;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        eq;

  logic        ready_a, ready_b;
  logic [15:0] pc_a;
  logic [3:0]  pc_b;
  logic [4:0]  ad1_a, ad2_a, ad3_a, ad1_b, ad2_b, ad3_b;
  logic        we3_a, we3_b;
  logic [7:0]  imm_a, imm_b;
  logic        alusrc_a, alusrc_b;
  logic [2:0]  aluctrl_a, aluctrl_b;
  logic        illegal_a, illegal_b;

  int          n_checks;
  int          n_fail;
  logic [31:0] pc_model;

  rf_alu_sequencer #(.D_WIDTH(8), .A_WIDTH(5), .PC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ready_a),
    .instr(instr), .pc(pc_a), .eq(eq), .ad1(ad1_a), .ad2(ad2_a), .ad3(ad3_a),
    .we3(we3_a), .imm_op(imm_a), .alusrc(alusrc_a), .aluctrl(aluctrl_a),
    .illegal(illegal_a)
  );

  rf_alu_sequencer #(.D_WIDTH(8), .A_WIDTH(5), .PC_WIDTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ready_b),
    .instr(instr), .pc(pc_b), .eq(eq), .ad1(ad1_b), .ad2(ad2_b), .ad3(ad3_b),
    .we3(we3_b), .imm_op(imm_b), .alusrc(alusrc_b), .aluctrl(aluctrl_b),
    .illegal(illegal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_pc(input string tag);
    check({tag, "_pc16"}, 32'(pc_a), {16'h0, pc_model[15:0]});
    check({tag, "_pc4"},  32'(pc_b), {28'h0, pc_model[3:0]});
  endtask

  task automatic check_ctrl_idle(input string tag);
    check({tag, "_we3"}, 32'(we3_a | we3_b), 32'd0);
  endtask

  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
    if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0000000) return K_ADD;
    if (op == 7'b0110011 && f3 == 3'b000 && f7 == 7'b0100000) return K_SUB;
    if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
    if (op == 7'b1100011 && f3 == 3'b001) return K_BNE;
    return K_ILL;
  endfunction

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    pc_model = 32'h0;
    check({tag, "_illegal"}, 32'(illegal_a | illegal_b), 32'd0);
    check({tag, "_ready"}, 32'(ready_a & ready_b), 32'd1);
    check_pc(tag);
    check_ctrl_idle(tag);
    check({tag, "_ad3"}, 32'(ad3_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic eqv, input int stall);
    int          k;
    logic [31:0] iv;
    logic [31:0] bv;
    logic        taken;
    k = classify(w);
    for (int i = 0; i < stall; i++) begin
      instr_valid = 1'b0;
      instr = $urandom;
      eq = 1'($urandom);
      @(negedge clk);
      check("stall_ready", 32'(ready_a & ready_b), 32'd1);
      check_pc("stall");
    end
    check("fetch_ready", 32'(ready_a), 32'd1);
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    // DECODE: the bus may now carry anything
    instr_valid = 1'($urandom);
    instr = $urandom;
    eq = eqv;
    check("dec_ready", 32'(ready_a | ready_b), 32'd0);
    check_ctrl_idle("dec");
    check_pc("dec");
    if (k == K_ILL) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("trap_illegal", 32'(illegal_a & illegal_b), 32'd1);
        check("trap_ready", 32'(ready_a | ready_b), 32'd0);
        check_ctrl_idle("trap");
        check_pc("trap");
      end
      async_reset("trap_rst");
      instr_valid = 1'b0;
      return;
    end
    iv = {{20{w[31]}}, w[31:20]};
    check("ad1", 32'(ad1_a), 32'(w[19:15]));
    check("ad2", 32'(ad2_a), 32'(w[24:20]));
    check("ad3", 32'(ad3_a), 32'(w[11:7]));
    check("alusrc", 32'(alusrc_a), (k == K_ADDI) ? 32'd1 : 32'd0);
    check("aluctrl", 32'(aluctrl_a), (k == K_ADDI || k == K_ADD) ? 32'd0 : 32'd1);
    if (k == K_ADDI) check("imm_op", 32'(imm_a), {24'h0, iv[7:0]});
    check("illegal", 32'(illegal_a), 32'd0);
    @(negedge clk);
    // EXECUTE: eq must stay put until the closing edge
    instr_valid = 1'($urandom);
    instr = $urandom;
    check("exe_ready", 32'(ready_a), 32'd0);
    check_ctrl_idle("exe");
    check("exe_ad3", 32'(ad3_a), 32'(w[11:7]));
    check_pc("exe");
    if (k == K_BEQ || k == K_BNE) begin
      bv = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      taken = (k == K_BEQ) ? eqv : !eqv;
      pc_model = taken ? pc_model + bv : pc_model + 32'd4;
      instr_valid = 1'b0;
      @(negedge clk);
      eq = 1'($urandom);
      check("br_ready", 32'(ready_a & ready_b), 32'd1);
      check_ctrl_idle("br");
      check_pc("br");
    end else begin
      instr_valid = 1'b0;
      @(negedge clk);
      eq = 1'($urandom);
      check("wb_we3", 32'(we3_a), (w[11:7] != 5'd0) ? 32'd1 : 32'd0);
      check("wb_ready", 32'(ready_a), 32'd0);
      check_pc("wb");
      pc_model = pc_model + 32'd4;
      @(negedge clk);
      check("post_we3", 32'(we3_a), 32'd0);
      check("post_ready", 32'(ready_a & ready_b), 32'd1);
      check_pc("post");
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int          sel;
    logic [12:0] b;
    logic [31:0] w;
    sel = $urandom_range(0, 19);
    b = 13'($urandom) & 13'h1FFE;
    case (sel)
      0, 1, 2, 3: w = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
      4, 5, 6:    w = {7'b0000000, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0110011};
      7, 8, 9:    w = {7'b0100000, 5'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0110011};
      10, 11, 12, 13:
        w = {b[12], b[10:5], 5'($urandom), 5'($urandom), 3'b000, b[4:1], b[11], 7'b1100011};
      14, 15, 16, 17, 18:
        w = {b[12], b[10:5], 5'($urandom), 5'($urandom), 3'b001, b[4:1], b[11], 7'b1100011};
      default: begin
        w = 32'h0000007F;
        for (int i = 0; i < 50; i++) begin
          w = $urandom;
          if (classify(w) == K_ILL) break;
        end
        if (classify(w) != K_ILL) w = 32'h0000007F;
      end
    endcase
    return w;
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    pc_model = 32'h0;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 32'h0;
    eq = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_ad", 32'({ad1_a, ad2_a, ad3_a}), 32'd0);
    check("rst_imm", 32'(imm_a), 32'd0);
    check("rst_ctl", 32'({we3_a, alusrc_a, aluctrl_a, illegal_a}), 32'd0);
    check_pc("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(32'h00500093, 1'b0, 0);
    run_instr(32'h00108133, 1'b0, 0);
    run_instr(32'h401101B3, 1'b0, 0);
    run_instr(32'hFE209CE3, 1'b0, 0);
    run_instr(32'hFE209CE3, 1'b1, 0);
    run_instr(32'h00700013, 1'b0, 5);
    run_instr(32'h00500093, 1'b0, 0);

    // reset during EXECUTE of an ADDI: no write may follow
    instr = 32'h00900293;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    async_reset("mid_exe");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_exe_after_we3", 32'(we3_a), 32'd0);
      check("mid_exe_after_ready", 32'(ready_a), 32'd1);
    end

    for (int i = 0; i < 4; i++) run_instr(32'h00108133, 1'b0, 0);
    run_instr(32'h0000007F, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(), 1'($urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_alu_sequencer.md
Name: rf_alu_sequencer

Overview:
- Multi-cycle control FSM that sequences the register-file/ALU datapath for a small RV32I subset: ADDI, ADD, SUB, BEQ, BNE.
- Fetches instructions over a valid/ready handshake and drives read/write addresses, write enable, immediate, operand select and ALU control.
- Samples the ALU `eq` flag to resolve branches and owns the program counter.
- Sits between instruction memory and the reg_file datapath.

Parameters:
- D_WIDTH, 8: datapath width; width of the `imm_op` output.
- A_WIDTH, 5: register address width.
- PC_WIDTH, 16: program counter width.
- PC_RESET, 0: PC value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction word valid.
- instr_ready  out  1  sequencer accepts an instruction.
- instr  in  32  instruction word.
- pc  out  PC_WIDTH  address of the current instruction.
- eq  in  1  ALU equality flag (operands equal).
- ad1  out  A_WIDTH  read address 1 (rs1).
- ad2  out  A_WIDTH  read address 2 (rs2).
- ad3  out  A_WIDTH  write address (rd).
- we3  out  1  register write enable.
- imm_op  out  D_WIDTH  sign-extended immediate, truncated to D_WIDTH.
- alusrc  out  1  0 = rd2 operand, 1 = imm_op operand.
- aluctrl  out  3  ALU operation: ADD=3'b000, SUB=3'b001.
- illegal  out  1  sticky unsupported-instruction flag.

Behaviour:
- Reset (async assert, sync release):
  - state=FETCH, pc=PC_RESET.
  - ad1, ad2, ad3, imm_op, aluctrl: 0; we3, alusrc, illegal: 0.
  - The latched instruction register is cleared.
  - Reset mid-instruction aborts it; no write occurs.
- All outputs are registered. Control outputs hold stable from DECODE through WRITEBACK.
- FETCH:
  - instr_ready=1.
  - On instr_valid && instr_ready: latch instr and go to DECODE.
  - Otherwise stay; pc holds.
  - instr_ready=0 in every other state.
- DECODE:
  - Drive ad1=instr[19:15], ad2=instr[24:20], ad3=instr[11:7].
  - Classify by opcode/funct3/funct7:
    - ADDI: opcode 0010011, funct3 000.
    - ADD: opcode 0110011, funct3 000, funct7 0000000.
    - SUB: opcode 0110011, funct3 000, funct7 0100000.
    - BEQ: opcode 1100011, funct3 000.
    - BNE: opcode 1100011, funct3 001.
  - Anything else goes to TRAP.
  - ADDI: alusrc=1, aluctrl=ADD, imm_op=sext(instr[31:20]) truncated to D_WIDTH.
  - ADD/SUB: alusrc=0, aluctrl=ADD/SUB.
  - Branches: alusrc=0, aluctrl=SUB.
- EXECUTE:
  - One cycle for the datapath to settle.
  - ALU ops go to WRITEBACK.
  - Branches sample eq at the end of the cycle. Taken when (BEQ && eq) || (BNE && !eq).
  - Taken branch: pc <= pc + sext(B-imm). Not taken: pc <= pc+4. Then go to FETCH.
- WRITEBACK:
  - we3=1 for exactly one cycle, unless ad3==0 (x0 writes suppressed, we3 stays 0).
  - pc <= pc+4; go to FETCH. we3 deasserts on exit.
- TRAP:
  - illegal=1, we3=0, instr_ready=0, pc frozen.
  - Leaves only via reset.
- Latency from accepted handshake:
  - ALU op: 4 cycles (DECODE, EXECUTE, WRITEBACK, FETCH); we3 is high in the 3rd cycle.
  - Branch: 3 cycles.
- PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- B-imm is the 13-bit sign-extended immediate {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- instr_valid dropping while not in FETCH is ignored. The instruction is held internally.

Decomposition:
- Shared package rv_ctrl_pkg:
  - state enum (FETCH, DECODE, EXECUTE, WRITEBACK, TRAP).
  - aluctrl localparams ALU_ADD, ALU_SUB.
  - opcode constants OP_IMM, OP_REG, OP_BRANCH.
  - funct3/funct7 constants.
- One sub-module is natural: rv_decoder, combinational. It takes instr and returns class, register fields and sign-extended immediates.
- The FSM and PC stay in rf_alu_sequencer.

Test Plan:
- ADDI: reset, then instr=0x00500093 (addi x1,x0,5) with valid held high.
  - -> ad1=0, ad3=1, alusrc=1, imm_op=8'h05, aluctrl=000.
  - -> we3=1 exactly one cycle at handshake+3; pc 0->4.
- ADD then SUB: instr 0x00108133 (add x2,x1,x1), then 0x401101B3 (sub x3,x2,x1).
  - -> ad1=1, ad2=1, ad3=2, alusrc=0, aluctrl=000; then aluctrl=001, ad3=3.
  - -> pc 4->8->12.
- BNE: pc=12, instr=0xFE209CE3 (bne x1,x2,-8).
  - eq=0 -> pc=4, we3 never asserted.
  - Repeat with eq=1 -> pc=16.
- Write to x0 and stall: instr=0x00700013 (addi x0,x0,7) -> we3 stays 0, pc advances 4.
  - instr_valid low 5 cycles in FETCH -> instr_ready stays 1, pc holds.
- Illegal opcode: instr=0x0000007F -> illegal=1 from the next state onward, instr_ready=0, pc frozen.
  - Assert rst_n=0 asynchronously mid-TRAP -> illegal=0, pc=PC_RESET immediately.
- Reset mid-instruction and PC wrap:
  - rst_n pulsed low during EXECUTE of an ADDI -> no we3 pulse, state FETCH.
  - With PC_WIDTH=4 and pc=12, an ALU op -> pc wraps to 0.
